// File: rtl/k580vt57_dma.sv
// i8257 / K580VT57-compatible 4-channel DMA controller with CPU register port and bus arbitration.
// Optional feature: define DMA_ROTATE_PRIO_EN to make mode[4] select rotating channel priority.
module k580vt57_dma #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_dma,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        omemr,
  output logic        omemw,
  output logic        oior,
  output logic        oiow,
  output logic        tc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SREQ,
    ST_S1,
    ST_S2,
    ST_S3
  } state_t;

  state_t      state;
  logic [15:0] addr    [4];
  logic [13:0] cnt     [4];
  logic [1:0]  mode_ch [4];
  logic [7:0]  mode;
  logic [3:0]  tc_flag;
  logic        update;
  logic        ff;
  logic [1:0]  ch;
  logic [2:0]  wait_cnt;
  logic        iwe_q;
  logic        ird_q;

  logic        we_edge;
  logic        rd_edge;
  logic [1:0]  reg_ch;
  logic [3:0]  req;
  logic [3:0]  ch_oh;
  logic [3:0]  tc_stop_mask;
  logic [3:0]  burst_req;
  logic [1:0]  prio_start;
  logic [1:0]  winner;
  logic        unused_bits;

  // Returns the first requesting channel at or after 'start', wrapping round.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign we_edge      = !iwe_n && iwe_q;
  assign rd_edge      = ird_n && !ird_q;
  assign reg_ch       = iaddr[2:1];
  assign req          = drq & mode[3:0];
  assign ch_oh        = 4'b0001 << ch;
  assign tc_stop_mask = (mode[6] && tc) ? ch_oh : 4'b0000;
  assign burst_req    = drq & mode[3:0] & ~tc_stop_mask;

`ifdef DMA_ROTATE_PRIO_EN
  // ch still holds the last-served channel, so starting one past it makes that channel lowest.
  assign prio_start  = mode[4] ? ch + 2'd1 : 2'd0;
  assign unused_bits = mode[5];
`else
  assign prio_start  = 2'd0;
  assign unused_bits = ^mode[5:4];
`endif

  assign winner = pick((state == ST_S3) ? burst_req : req, prio_start);

  always_comb begin
    odata = 8'h00;
    if (iaddr == 4'd8) begin
      odata = {3'b000, update, tc_flag};
    end else if (!iaddr[3]) begin
      if (!iaddr[0]) odata = ff ? addr[reg_ch][15:8] : addr[reg_ch][7:0];
      else           odata = ff ? {mode_ch[reg_ch], cnt[reg_ch][13:8]} : cnt[reg_ch][7:0];
    end
  end

  always_ff @(posedge clk) begin
    iwe_q  <= iwe_n;
    ird_q  <= ird_n;
    update <= 1'b0;
    if (reset) begin
      state    <= ST_IDLE;
      hrq      <= 1'b0;
      dack     <= 4'b0000;
      oaddr    <= 16'h0000;
      omemr    <= 1'b0;
      omemw    <= 1'b0;
      oior     <= 1'b0;
      oiow     <= 1'b0;
      tc       <= 1'b0;
      mode     <= 8'h00;
      tc_flag  <= 4'b0000;
      ff       <= 1'b0;
      ch       <= 2'd3;
      wait_cnt <= 3'd0;
      iwe_q    <= 1'b1;
      ird_q    <= 1'b1;
    end else begin
      if (ce_dma) begin
        case (state)
          ST_IDLE: begin
            if (|req) begin
              hrq   <= 1'b1;
              state <= ST_SREQ;
            end
          end
          ST_SREQ: begin
            if (!(|req)) begin
              hrq   <= 1'b0;
              state <= ST_IDLE;
            end else if (hlda) begin
              ch    <= winner;
              state <= ST_S1;
            end
          end
          ST_S1: begin
            oaddr    <= addr[ch];
            dack     <= ch_oh;
            wait_cnt <= 3'd0;
            state    <= ST_S2;
          end
          ST_S2: begin
            omemr <= (mode_ch[ch] == 2'b10);
            oiow  <= (mode_ch[ch] == 2'b10);
            omemw <= (mode_ch[ch] == 2'b01);
            oior  <= (mode_ch[ch] == 2'b01);
            tc    <= (cnt[ch] == 14'd0);
            if (wait_cnt == 3'(WAIT_STATES)) state <= ST_S3;
            else wait_cnt <= wait_cnt + 3'd1;
          end
          ST_S3: begin
            omemr    <= 1'b0;
            omemw    <= 1'b0;
            oior     <= 1'b0;
            oiow     <= 1'b0;
            tc       <= 1'b0;
            dack     <= 4'b0000;
            addr[ch] <= addr[ch] + 16'd1;
            cnt[ch]  <= cnt[ch] - 14'd1;
            if (tc) begin
              tc_flag[ch] <= 1'b1;
              mode[3:0]   <= mode[3:0] & ~tc_stop_mask;
              if (mode[7] && ch == 2'd2) begin
                addr[2]    <= addr[3];
                cnt[2]     <= cnt[3];
                mode_ch[2] <= mode_ch[3];
                update     <= 1'b1;
              end
            end
            if ((|burst_req) && hlda) begin
              ch    <= winner;
              state <= ST_S1;
            end else begin
              hrq   <= 1'b0;
              oaddr <= 16'h0000;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // CPU accesses come after the FSM so a same-clock register write overrides the S3 update.
      if (we_edge) begin
        if (iaddr == 4'd8) begin
          mode <= idata;
          ff   <= 1'b0;
        end else if (!iaddr[3]) begin
          if (!iaddr[0]) begin
            if (ff) addr[reg_ch][15:8] <= idata;
            else    addr[reg_ch][7:0]  <= idata;
          end else begin
            if (ff) begin
              mode_ch[reg_ch]    <= idata[7:6];
              cnt[reg_ch][13:8]  <= idata[5:0];
            end else begin
              cnt[reg_ch][7:0]   <= idata;
            end
          end
          ff <= ~ff;
        end
      end

      if (rd_edge) begin
        if (iaddr == 4'd8)  tc_flag <= 4'b0000;
        else if (!iaddr[3]) ff      <= ~ff;
      end
    end
  end

endmodule

// File: tb/tb_k580vt57_dma.sv
// Directed bench for k580vt57_dma: per-byte scoreboard on dack windows plus register/status checks.
`timescale 1ns/1ps
module tb_k580vt57_dma;
  localparam int W = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_dma = 1'b0;
  logic [3:0]  iaddr = 4'd0;
  logic [7:0]  idata = 8'h00;
  logic [7:0]  odata;
  logic        iwe_n = 1'b1;
  logic        ird_n = 1'b1;
  logic [3:0]  drq = 4'b0000;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda = 1'b0;
  logic [15:0] oaddr;
  logic        omemr, omemw, oior, oiow, tc;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic        auto_drop = 1'b0;
  int          upd_clks = 0;
  logic [3:0]  prev_dack = 4'b0000;
  logic [3:0]  cur_dack = 4'b0000;
  logic [15:0] cur_addr = 16'h0000;
  logic [4:0]  seen = 5'b00000;
  logic [W-1:0] got;
  logic [W-1:0] want;
  logic [7:0]  rd;

  k580vt57_dma #(.WAIT_STATES(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce_dma (ce_dma),
    .iaddr  (iaddr),
    .idata  (idata),
    .odata  (odata),
    .iwe_n  (iwe_n),
    .ird_n  (ird_n),
    .drq    (drq),
    .dack   (dack),
    .hrq    (hrq),
    .hlda   (hlda),
    .oaddr  (oaddr),
    .omemr  (omemr),
    .omemw  (omemw),
    .oior   (oior),
    .oiow   (oiow),
    .tc     (tc)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk); iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); iaddr = a; ird_n = 1'b0;
    @(negedge clk); d = odata; ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] v);
    cpu_wr(a, v[7:0]);
    cpu_wr(a, v[15:8]);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] expv);
    logic [7:0] d;
    cpu_rd(a, d);
    check(tag, {24'h0, d}, {24'h0, expv});
  endtask

  task automatic push_byte(input int c, input logic [15:0] a, input logic [1:0] m, input logic t);
    logic rd_m;
    logic wr_m;
    logic [3:0] oh;
    rd_m = (m == 2'b10);
    wr_m = (m == 2'b01);
    oh   = 4'b0001 << c;
    exp_q.push_back({oh, a, rd_m, wr_m, wr_m, rd_m, t});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hrq) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_hrq_low"}, {31'b0, hrq}, 0);
  endtask

  // Environment: random ce, arbiter grant follows hrq, requester drops drq on its terminal byte
  initial forever begin
    @(negedge clk);
    ce_dma = ($urandom_range(0, 3) != 0);
    hlda   = hrq;
    if (auto_drop && tc) drq = drq & ~dack;
  end

  // Scoreboard monitor: one item per dack window
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_dack = 4'b0000;
      seen      = 5'b00000;
    end else begin
      if (dack != 4'b0000) begin
        if (prev_dack == 4'b0000) begin
          cur_dack = dack;
          cur_addr = oaddr;
          seen     = 5'b00000;
        end
        seen = seen | {omemr, omemw, oior, oiow, tc};
      end else if (prev_dack != 4'b0000) begin
        got = {cur_dack, cur_addr, seen};
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", {7'b0, got}, 32'h0);
        end else begin
          want = exp_q.pop_front();
          check("sb_byte", {7'b0, got}, {7'b0, want});
        end
      end
      prev_dack = dack;
      if (iaddr == 4'd8 && odata[4]) upd_clks++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Directed sequence
  initial begin
    int n;
    repeat (5) @(negedge clk);
    check("rst_outputs", {dack, hrq, tc, omemr, omemw, oior, oiow, oaddr}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {dack, hrq, tc, omemr, omemw, oior, oiow, oaddr}, 0);
    rd_check("rst_status", 4'd8, 8'h00);

    // 1: 80-byte read burst on ch2
    cpu_wr(4'd8, 8'h04);
    wr16(4'd4, 16'h76D0);
    wr16(4'd5, 16'h804F);
    for (int i = 0; i < 80; i++) push_byte(2, 16'h76D0 + 16'(i), 2'b10, i == 79);
    auto_drop = 1'b1;
    drq = 4'b0100;
    wait_done("t1", 3000);
    rd_check("t1_status", 4'd8, 8'h04);
    rd_check("t1_status_cleared", 4'd8, 8'h00);
    rd_check("t1_addr_lo", 4'd4, 8'h20);
    rd_check("t1_addr_hi", 4'd4, 8'h77);
    rd_check("t1_cnt_lo", 4'd5, 8'hFF);
    rd_check("t1_cnt_hi", 4'd5, 8'hBF);

    // 2: autoload ch2 from ch3
    cpu_wr(4'd8, 8'h84);
    wr16(4'd4, 16'h1000);
    wr16(4'd5, 16'h8000);
    wr16(4'd6, 16'h8000);
    wr16(4'd7, 16'h804F);
    iaddr = 4'd8;
    upd_clks = 0;
    push_byte(2, 16'h1000, 2'b10, 1'b1);
    drq = 4'b0100;
    wait_done("t2", 500);
    check("t2_update_pulse_clks", upd_clks, 1);
    rd_check("t2_status", 4'd8, 8'h04);
    rd_check("t2_addr_lo", 4'd4, 8'h00);
    rd_check("t2_addr_hi", 4'd4, 8'h80);
    rd_check("t2_cnt_lo", 4'd5, 8'h4F);
    rd_check("t2_cnt_hi", 4'd5, 8'h80);
    auto_drop = 1'b0;
    push_byte(2, 16'h8000, 2'b10, 1'b0);
    drq = 4'b0100;
    n = 0;
    while (dack == 4'b0000 && n < 200) begin @(negedge clk); n++; end
    check("t2_en2_still_set", {28'b0, dack}, 4'b0100);
    drq = 4'b0000;
    wait_done("t2b", 500);

    // 3: two channels, mode[4] set (ignored unless rotating priority is built in)
    cpu_wr(4'd8, 8'h15);
    wr16(4'd0, 16'h0100);
    wr16(4'd1, 16'h4001);
    wr16(4'd4, 16'h0200);
    wr16(4'd5, 16'h8001);
`ifdef DMA_ROTATE_PRIO_EN
    push_byte(0, 16'h0100, 2'b01, 1'b0);
    push_byte(2, 16'h0200, 2'b10, 1'b0);
    push_byte(0, 16'h0101, 2'b01, 1'b1);
    push_byte(2, 16'h0201, 2'b10, 1'b1);
`else
    push_byte(0, 16'h0100, 2'b01, 1'b0);
    push_byte(0, 16'h0101, 2'b01, 1'b1);
    push_byte(2, 16'h0200, 2'b10, 1'b0);
    push_byte(2, 16'h0201, 2'b10, 1'b1);
`endif
    auto_drop = 1'b1;
    drq = 4'b0101;
    wait_done("t3", 500);
    rd_check("t3_status", 4'd8, 8'h05);

    // 4: TC-stop on ch1 with drq held
    cpu_wr(4'd8, 8'h42);
    wr16(4'd2, 16'h0300);
    wr16(4'd3, 16'h4002);
    push_byte(1, 16'h0300, 2'b01, 1'b0);
    push_byte(1, 16'h0301, 2'b01, 1'b0);
    push_byte(1, 16'h0302, 2'b01, 1'b1);
    auto_drop = 1'b0;
    drq = 4'b0010;
    wait_done("t4", 500);
    repeat (20) @(negedge clk);
    check("t4_no_rerequest", {31'b0, hrq}, 0);
    check("t4_no_extra_bytes", exp_q.size(), 0);
    drq = 4'b0000;
    rd_check("t4_status", 4'd8, 8'h02);
    rd_check("t4_status_cleared", 4'd8, 8'h00);

    // 5: address wrap, then reset in the middle of S2
    cpu_wr(4'd8, 8'h01);
    wr16(4'd0, 16'hFFFF);
    wr16(4'd1, 16'h8001);
    push_byte(0, 16'hFFFF, 2'b10, 1'b0);
    push_byte(0, 16'h0000, 2'b10, 1'b1);
    auto_drop = 1'b1;
    drq = 4'b0001;
    wait_done("t5", 500);
    rd_check("t5_addr_lo", 4'd0, 8'h01);
    rd_check("t5_addr_hi", 4'd0, 8'h00);
    rd_check("t5_status", 4'd8, 8'h01);
    wr16(4'd0, 16'h4000);
    wr16(4'd1, 16'h8010);
    auto_drop = 1'b0;
    drq = 4'b0001;
    n = 0;
    while (!omemr && n < 200) begin @(negedge clk); n++; end
    check("t5_s2_reached", {31'b0, omemr}, 1);
    reset = 1'b1;
    drq = 4'b0000;
    @(negedge clk);
    check("t5_rst_mid_s2", {dack, hrq, omemr, tc, oaddr}, 0);
    @(negedge clk);
    reset = 1'b0;
    rd_check("t5_status_after_rst", 4'd8, 8'h00);

    // 6: byte flip-flop cleared by a mode write
    cpu_wr(4'd0, 8'h56);
    cpu_wr(4'd8, 8'h00);
    wr16(4'd0, 16'h1234);
    rd_check("t6_ff_lo", 4'd0, 8'h34);
    rd_check("t6_ff_hi", 4'd0, 8'h12);

    check("end_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
